// File: rtl/euros_para_centimos.sv
// euros_para_centimos: sequential euros+cents to total cents converter, one BASE added per clock, with range/overflow error
module euros_para_centimos #(
  parameter int W_IN = 14,
  parameter int W_OUT = 9,
  parameter int BASE = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W_IN-1:0]  euros_inteiro,
  input  logic [W_IN-1:0]  euros_fracao,
  output logic [W_OUT-1:0] centimos,
  output logic             done,
  output logic             busy,
  output logic             erro
);
  localparam int MAX_OUT = (1 << W_OUT) - 1;
  localparam logic [W_IN-1:0] MAX_E = W_IN'(MAX_OUT / BASE);
  localparam logic [W_IN-1:0] BASE_IN = W_IN'(BASE);
  localparam logic [W_OUT+1:0] BASE_X = (W_OUT+2)'(BASE);
  localparam logic [W_OUT+1:0] MAX_X = (W_OUT+2)'(MAX_OUT);
  typedef enum logic [2:0] {IDLE, CHECK, ACCUM, DONE, ERR} state_t;
  state_t state;
  logic [W_IN-1:0] euros_r, fracao_r, cnt;
  logic [W_OUT:0] acc;
  logic [W_OUT+1:0] acc_nxt;
  assign acc_nxt = {1'b0, acc} + BASE_X;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      centimos <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      erro <= 1'b0;
      acc <= '0;
      cnt <= '0;
      euros_r <= '0;
      fracao_r <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          euros_r <= euros_inteiro;
          fracao_r <= euros_fracao;
          busy <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (fracao_r >= BASE_IN || euros_r > MAX_E) begin
          centimos <= '0;
          erro <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          state <= ERR;
        end else begin
          acc <= (W_OUT+1)'(fracao_r);
          cnt <= euros_r;
          state <= ACCUM;
        end
        ACCUM: if (cnt == '0) begin
          centimos <= acc[W_OUT-1:0];
          erro <= 1'b0;
          done <= 1'b1;
          busy <= 1'b0;
          state <= DONE;
        end else if (acc_nxt > MAX_X) begin
          centimos <= '0;
          erro <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
          state <= ERR;
        end else begin
          acc <= acc_nxt[W_OUT:0];
          cnt <= cnt - 1'b1;
        end
        DONE, ERR: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_euros_para_centimos.sv
// tb_euros_para_centimos: directed checks of conversion results, latency, errors, ignored starts and reset abort
module tb_euros_para_centimos;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [13:0] euros_inteiro = '0;
  logic [13:0] euros_fracao = '0;
  logic [8:0] centimos;
  logic done, busy, erro;
  int checks = 0;
  int failures = 0;

  euros_para_centimos dut (
    .clk(clk), .reset(reset), .start(start),
    .euros_inteiro(euros_inteiro), .euros_fracao(euros_fracao),
    .centimos(centimos), .done(done), .busy(busy), .erro(erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // start at edge E0, then expect done exactly lat edges later
  task automatic run(input int e, input int f, input int lat, input int exp_c, input logic exp_err);
    euros_inteiro = 14'(e);
    euros_fracao = 14'(f);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("busy_e0_%0d_%0d", e, f), 32'(busy), 32'd1);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k < lat) begin
        chk($sformatf("early_done_%0d_%0d_k%0d", e, f, k), 32'(done), 32'd0);
        chk($sformatf("busy_%0d_%0d_k%0d", e, f, k), 32'(busy), 32'd1);
      end
    end
    chk($sformatf("done_%0d_%0d", e, f), 32'(done), 32'd1);
    chk($sformatf("busy_off_%0d_%0d", e, f), 32'(busy), 32'd0);
    chk($sformatf("centimos_%0d_%0d", e, f), 32'(centimos), 32'(exp_c));
    chk($sformatf("erro_%0d_%0d", e, f), 32'(erro), 32'(exp_err));
    tick();
    chk($sformatf("done_pulse_%0d_%0d", e, f), 32'(done), 32'd0);
    chk($sformatf("hold_%0d_%0d", e, f), 32'(centimos), 32'(exp_c));
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_centimos", 32'(centimos), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    reset = 1'b0;
    tick();
    run(3, 45, 5, 345, 1'b0);
    run(0, 0, 2, 0, 1'b0);
    run(5, 11, 7, 511, 1'b0);
    run(5, 12, 6, 0, 1'b1);
    run(0, 100, 1, 0, 1'b1);
    run(6, 0, 1, 0, 1'b1);
    run(1, 1, 3, 101, 1'b0);
    // second start while busy must be ignored, inputs changed after capture
    euros_inteiro = 14'd2;
    euros_fracao = 14'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    euros_inteiro = 14'd4;
    euros_fracao = 14'd0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_done_e2", 32'(done), 32'd0);
    tick();
    chk("mid_done_e3", 32'(done), 32'd0);
    tick();
    chk("mid_done_e4", 32'(done), 32'd1);
    chk("mid_centimos", 32'(centimos), 32'd250);
    chk("mid_erro", 32'(erro), 32'd0);
    for (int k = 5; k <= 11; k++) begin
      tick();
      chk($sformatf("mid_no_second_done_e%0d", k), 32'(done), 32'd0);
    end
    chk("mid_hold", 32'(centimos), 32'd250);
    // reset aborts an in-flight conversion
    euros_inteiro = 14'd4;
    euros_fracao = 14'd99;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_centimos", 32'(centimos), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_erro", 32'(erro), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("abort_no_done_%0d", k), 32'(done), 32'd0);
    end
    run(1, 1, 3, 101, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/euros_para_centimos.md
Name: euros_para_centimos

Overview:
- Sequential converter from a euro amount (integer part plus fraction in cents) to a total cent count for the machine's money datapath.
- It is the inverse of the existing centimos-to-euros split.
- Computes `centimos = euros_inteiro*BASE + euros_fracao` by iterative addition, one BASE per clock, under a start/done handshake.
- Range-checks inputs and result; flags errors instead of wrapping.

Parameters:
- W_IN, 14, width of euros_inteiro and euros_fracao inputs
- W_OUT, 9, width of centimos result; MAX_OUT = 2^W_OUT-1 (511)
- BASE, 100, cents per euro

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- euros_inteiro  input  W_IN  integer euros
- euros_fracao  input  W_IN  cents fraction, valid 0..BASE-1
- centimos  output  W_OUT  result, held until next done
- done  output  1  one-cycle pulse: result/erro valid
- busy  output  1  high from the edge after start accept until done pulse
- erro  output  1  error flag, updated with done

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; centimos=0, done=0, busy=0, erro=0; internal acc/cnt=0. Reset mid-conversion aborts it; no done pulse is produced.
- All outputs are registered.
- IDLE: busy=0. On an edge with start=1 (edge E0):
  - capture euros_inteiro and euros_fracao into internal registers;
  - go to CHECK; busy=1.
- CHECK (edge E0+1):
  - If fracao_r >= BASE or euros_r > MAX_OUT/BASE (5): go to ERR.
  - Else: acc = fracao_r (acc width W_OUT+1), cnt = euros_r; go to ACCUM.
- ACCUM, each edge:
  - If cnt==0: go to DONE.
  - Else if acc+BASE > MAX_OUT: go to ERR.
  - Else: acc += BASE, cnt -= 1.
- DONE: on the transition edge, centimos <= acc[W_OUT-1:0], erro <= 0, done <= 1, busy <= 0. Next edge returns to IDLE with done <= 0.
- ERR: on the transition edge, centimos <= 0, erro <= 1, done <= 1, busy <= 0. Next edge returns to IDLE.
- Latency:
  - Valid input with N euros: done high after edge E0+N+2.
  - Input range error: done high after edge E0+1.
  - Overflow: done high after the edge on which the overflowing add is detected.
- start while busy, or during the done cycle, is ignored; no queuing. start may be re-asserted on the first IDLE edge (back-to-back).
- Inputs are sampled only at E0; changes afterwards do not affect the result.
- erro and centimos hold their values between conversions; done is the only pulse.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then euros_inteiro=3, euros_fracao=45, start at E0 -> busy high E0+1..E0+5; done=1 after E0+5; centimos=345, erro=0.
- 0 euros, 0 fracao -> done after E0+2; centimos=0, erro=0.
- 5 euros, 11 fracao -> done after E0+7; centimos=511, erro=0. Then 5 euros, 12 fracao -> acc reaches 412 with cnt=1; done after E0+6 with erro=1, centimos=0.
- fracao=100 (or euros_inteiro=6) -> done after E0+1; erro=1, centimos=0; busy low again after E0+1.
- Start 2 euros/50; pulse start with 4/00 at E0+2; change inputs mid-conversion -> single done after E0+4 with centimos=250; second start ignored.
- Start 4/99, assert reset at E0+3 -> no done; all outputs 0 next cycle. A new start 1/01 then yields centimos=101 after its E0+3.
